read_c_addr_gen: RTL and testbench

Row-address generator for the read_C stage of the Sextans SpMM pipeline. It walks the rows of one C tile and computes each row's byte address as base + ((row × stride) << 2) through a pipelined multiplier. It emits one address per cycle on a valid/ready stream to the C memory-read issuer. Backpressure stalls the whole pipeline through a single clock-enable, so no address is dropped or duplicated.

---
 rtl/read_c_pkg.sv | 19 +
 rtl/read_c_row_mul.sv | 48 ++++
 rtl/read_c_addr_gen.sv | 127 ++++++++++++
 tb/tb_read_c_addr_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_c_pkg.sv
// read_C stage shared definitions: datapath widths,
// multiplier latency and the address-generator FSM states.
package read_c_pkg;

  localparam int ROW_W     = 14;
  localparam int STRIDE_W  = 28;
  localparam int PROD_W    = 32;
  localparam int ADDR_W    = 64;
  localparam int MUL_LAT   = 3;
  localparam int ELEM_LOG2 = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/read_c_row_mul.sv
// Pipelined {0,a} x signed b multiplier, MUL_LAT register stages, low PROD_W bits kept.
// Ports: clk, rst_n, ce (advance all stages), a (row), b (stride), p (product).
module read_c_row_mul #(
  parameter int ROW_W    = read_c_pkg::ROW_W,
  parameter int STRIDE_W = read_c_pkg::STRIDE_W,
  parameter int PROD_W   = read_c_pkg::PROD_W,
  parameter int MUL_LAT  = read_c_pkg::MUL_LAT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ce,
  input  logic [ROW_W-1:0]           a,
  input  logic signed [STRIDE_W-1:0] b,
  output logic [PROD_W-1:0]          p
);

  import read_c_pkg::*;

  logic signed [ROW_W:0]      a_q;
  logic signed [STRIDE_W-1:0] b_q;
  logic signed [PROD_W-1:0]   a_x;
  logic signed [PROD_W-1:0]   b_x;
  logic signed [PROD_W-1:0]   full;
  logic [PROD_W-1:0]          p_q [MUL_LAT-1];

  // Low PROD_W bits of a product depend only on the low
  // PROD_W bits of the sign-extended operands.
  assign a_x  = PROD_W'(a_q);
  assign b_x  = PROD_W'(b_q);
  assign full = a_x * b_x;
  assign p    = p_q[MUL_LAT-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < MUL_LAT - 1; i++)
        p_q[i] <= '0;
    end else if (ce) begin
      a_q    <= {1'b0, a};
      b_q    <= b;
      p_q[0] <= full;
      for (int i = 1; i < MUL_LAT - 1; i++)
        p_q[i] <= p_q[i-1];
    end
  end

endmodule

// File: rtl/read_c_addr_gen.sv
// read_C row-address generator: base + ((row*stride) << ELEM_LOG2) per row, valid/ready out.
// Ports: ap_clk, ap_rst_n, start/num_rows/stride/base_addr in, busy/done, addr_out/row_out/addr_valid, addr_ready.
module read_c_addr_gen #(
  parameter int ROW_W     = read_c_pkg::ROW_W,
  parameter int STRIDE_W  = read_c_pkg::STRIDE_W,
  parameter int PROD_W    = read_c_pkg::PROD_W,
  parameter int ADDR_W    = read_c_pkg::ADDR_W,
  parameter int MUL_LAT   = read_c_pkg::MUL_LAT,
  parameter int ELEM_LOG2 = read_c_pkg::ELEM_LOG2
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       start,
  input  logic [ROW_W-1:0]           num_rows,
  input  logic signed [STRIDE_W-1:0] stride,
  input  logic [ADDR_W-1:0]          base_addr,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_W-1:0]          addr_out,
  output logic [ROW_W-1:0]           row_out,
  output logic                       addr_valid,
  input  logic                       addr_ready
);

  import read_c_pkg::*;

  state_t                     state;
  state_t                     state_nx;
  logic                       ce;
  logic                       issue;
  logic                       last_row;
  logic [ROW_W-1:0]           rows_q;
  logic [ROW_W-1:0]           r;
  logic signed [STRIDE_W-1:0] stride_q;
  logic [ADDR_W-1:0]          base_q;
  logic [MUL_LAT:0]           v;
  logic [ROW_W-1:0]           row_pipe [MUL_LAT];
  logic [PROD_W-1:0]          prod;
  logic [ADDR_W-1:0]          prod_ext;

  // The top valid bit is the output register's valid, so
  // ready never reaches addr_valid combinationally.
  assign addr_valid = v[MUL_LAT];
  assign ce         = addr_ready | ~addr_valid;
  assign issue      = (state == RUN) & ce;
  assign last_row   = (r == rows_q - 1'b1);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign prod_ext   = {{(ADDR_W-PROD_W){prod[PROD_W-1]}}, prod};

  read_c_row_mul #(
    .ROW_W   (ROW_W),
    .STRIDE_W(STRIDE_W),
    .PROD_W  (PROD_W),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk  (ap_clk),
    .rst_n(ap_rst_n),
    .ce   (ce),
    .a    (r),
    .b    (stride_q),
    .p    (prod)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start)
          state_nx = (num_rows == '0) ? DONE : RUN;
      RUN:
        if (issue && last_row)
          state_nx = DRAIN;
      DRAIN:
        if (v[MUL_LAT-1:0] == '0 &&
            (!addr_valid || addr_ready))
          state_nx = DONE;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rows_q   <= '0;
      stride_q <= '0;
      base_q   <= '0;
      r        <= '0;
    end else if (state == IDLE && start) begin
      rows_q   <= num_rows;
      stride_q <= stride;
      base_q   <= base_addr;
      r        <= '0;
    end else if (issue) begin
      r <= r + 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v        <= '0;
      addr_out <= '0;
      row_out  <= '0;
      for (int i = 0; i < MUL_LAT; i++)
        row_pipe[i] <= '0;
    end else if (ce) begin
      v           <= {v[MUL_LAT-1:0], state == RUN};
      row_pipe[0] <= r;
      for (int i = 1; i < MUL_LAT; i++)
        row_pipe[i] <= row_pipe[i-1];
      if (v[MUL_LAT-1]) begin
        addr_out <= base_q + (prod_ext << ELEM_LOG2);
        row_out  <= row_pipe[MUL_LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_read_c_addr_gen.sv
// Directed bench for read_c_addr_gen and its multiplier.
// Cycle 0 is the cycle in which start is high.
module tb_read_c_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] num_rows = '0;
  logic [27:0] stride = '0;
  logic [63:0] base_addr = '0;
  logic        addr_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [63:0] addr_out;
  logic [13:0] row_out;
  logic        addr_valid;

  logic        m_ce = 1'b0;
  logic [13:0] m_a = '0;
  logic [27:0] m_b = '0;
  logic [31:0] m_p;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int busy_cnt = 0;
  int valid_cnt = 0;
  int first_valid = -1;
  int stall_cnt = 0;
  int rmode = 0;
  int stall_left = 0;

  logic        prev_stall = 1'b0;
  logic [63:0] prev_a = '0;
  logic [13:0] prev_r = '0;

  logic [63:0] addr_q [$];
  logic [13:0] row_q [$];

  read_c_addr_gen dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .start     (start),
    .num_rows  (num_rows),
    .stride    (stride),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .addr_out  (addr_out),
    .row_out   (row_out),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready)
  );

  read_c_row_mul u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (m_ce),
    .a    (m_a),
    .b    (m_b),
    .p    (m_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] b,
                                        input int r,
                                        input logic [27:0] s);
    longint sv;
    longint p;
    int     t;
    longint ex;
    sv = longint'($signed(s));
    p  = longint'(r) * sv;
    t  = int'(p);
    ex = longint'(t);
    return b + 64'(ex * 4);
  endfunction

  always @(posedge clk) begin
    #1;
    if (rmode == 1 && addr_q.size() >= 2) begin
      if (stall_left > 0) begin
        addr_ready = 1'b0;
        stall_left--;
      end else begin
        addr_ready = 1'($urandom_range(0, 1));
      end
    end else begin
      addr_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc - t0;
      end
      if (addr_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc - t0;
      end
      if (prev_stall) begin
        check("stall_valid", 64'(addr_valid), 64'd1);
        check("stall_addr", addr_out, prev_a);
        check("stall_row", 64'(row_out), 64'(prev_r));
      end
      if (addr_valid && addr_ready) begin
        addr_q.push_back(addr_out);
        row_q.push_back(row_out);
      end
      if (addr_valid && !addr_ready) stall_cnt++;
      prev_stall = addr_valid && !addr_ready;
      prev_a = addr_out;
      prev_r = row_out;
    end
  end

  task automatic kick(input logic [13:0] n,
                      input logic [27:0] s,
                      input logic [63:0] b);
    addr_q.delete();
    row_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    busy_cnt = 0;
    valid_cnt = 0;
    first_valid = -1;
    stall_cnt = 0;
    @(posedge clk);
    #1;
    num_rows = n;
    stride = s;
    base_addr = b;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != 0) break;
    end
    check("done_seen", 64'(done_cnt), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_rows(input string tag,
                            input int n,
                            input logic [27:0] s,
                            input logic [63:0] b);
    check({tag, "_count"}, 64'(addr_q.size()), 64'(n));
    for (int i = 0; i < n && i < addr_q.size(); i++) begin
      check({tag, "_addr"}, addr_q[i], model(b, i, s));
      check({tag, "_row"}, 64'(row_q[i]), 64'(i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 64'({busy, done, addr_valid}), 64'd0);
    check("rst_addr", addr_out, 64'd0);
    check("rst_row", 64'(row_out), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // basic three-row job
    kick(14'd3, 28'd100, 64'h1000);
    wait_done(40);
    check("t1_count", 64'(addr_q.size()), 64'd3);
    if (addr_q.size() == 3) begin
      check("t1_a0", addr_q[0], 64'h1000);
      check("t1_a1", addr_q[1], 64'h1190);
      check("t1_a2", addr_q[2], 64'h1320);
      check("t1_r2", 64'(row_q[2]), 64'd2);
    end
    check("t1_first_valid", 64'(first_valid), 64'd5);
    check("t1_done_cyc", 64'(done_cyc), 64'd8);
    check("t1_busy_cycles", 64'(busy_cnt), 64'd8);

    // negative stride
    kick(14'd2, 28'hFFFFFFF, 64'h10);
    wait_done(40);
    check("t2_count", 64'(addr_q.size()), 64'd2);
    if (addr_q.size() == 2) begin
      check("t2_a0", addr_q[0], 64'h10);
      check("t2_a1", addr_q[1], 64'h0C);
    end

    // empty job
    kick(14'd0, 28'd7, 64'h500);
    wait_done(10);
    check("t3_done_cyc", 64'(done_cyc), 64'd1);
    check("t3_valid_cycles", 64'(valid_cnt), 64'd0);
    check("t3_busy_cycles", 64'(busy_cnt), 64'd1);

    // backpressure: 5-cycle stall then random ready
    rmode = 1;
    stall_left = 5;
    kick(14'd8, 28'd4, 64'h2000);
    wait_done(400);
    rmode = 0;
    check_rows("t4", 8, 28'd4, 64'h2000);
    if (addr_q.size() == 8)
      check("t4_a7", addr_q[7], 64'h2070);
    check("t4_stalled", 64'(stall_cnt >= 5), 64'd1);

    // multiplier alone: truncation to 32 bits
    @(posedge clk);
    #1;
    m_ce = 1'b1;
    m_a = 14'd16383;
    m_b = 28'h7FFFFFF;
    repeat (3) @(posedge clk);
    #1;
    check("mul_trunc", 64'(m_p), 64'hF7FFC001);
    m_ce = 1'b0;
    m_a = 14'd1;
    repeat (3) @(posedge clk);
    #1;
    check("mul_hold", 64'(m_p), 64'hF7FFC001);

    // truncation through the top module
    kick(14'd20, 28'h7FFFFFF, 64'h0);
    wait_done(80);
    check_rows("t5", 20, 28'h7FFFFFF, 64'h0);
    if (addr_q.size() == 20) begin
      check("t5_r16", addr_q[16], 64'h0000_0001_FFFF_FFC0);
      check("t5_r19", addr_q[19], 64'hFFFF_FFFE_5FFF_FFB4);
    end

    // asynchronous reset mid-stream
    kick(14'd10, 28'd3, 64'h100);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (addr_q.size() >= 4) break;
    end
    check("t6_pre_hs", 64'(addr_q.size()), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ctrl", 64'({busy, done, addr_valid}), 64'd0);
    check("t6_rst_addr", addr_out, 64'd0);
    check("t6_rst_row", 64'(row_out), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_no_done", 64'(done_cnt), 64'd0);
    check("t6_idle", 64'({busy, addr_valid}), 64'd0);
    check("t6_no_more", 64'(addr_q.size()), 64'd4);

    kick(14'd3, 28'd5, 64'h40);
    wait_done(40);
    check_rows("t7", 3, 28'd5, 64'h40);
    if (addr_q.size() == 3) begin
      check("t7_a0", addr_q[0], 64'h40);
      check("t7_a2", addr_q[2], 64'h68);
    end
    check("t7_first_valid", 64'(first_valid), 64'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
